correlator_multi: RTL and testbench
===================================

CORRELATOR_MULTI -- requirements
Module: correlator_multi

Interface
REQ-001 Parameter N_CH, default 4; number of binary input channels, legal range 2..8.
REQ-002 Parameter MAX_WINDOW_LENGTH_EXP, default 16; counter width TIME_W, legal range 8..16.
REQ-003 Parameter MAX_SAMPLE_PERIOD_EXP, default 15; maximum sample period exponent.
REQ-004 Parameter PKTFIFO_DEPTH, default 64; packet FIFO depth in bytes, SHALL be >= 2*(N_CH+3).
REQ-005 i_clk  in  1  sole clock; all state on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_cg  in  1  clock gate; low SHALL hold all state.
REQ-008 i_x  in  N_CH  channel inputs, already synchronised to i_clk.
REQ-009 i_windowLengthExp  in  clog2(MAX_WINDOW_LENGTH_EXP+1)  window = 2^value samples.
REQ-010 i_samplePeriodExp  in  clog2(MAX_SAMPLE_PERIOD_EXP+1)  sample strobe every 2^value cycles.
REQ-011 i_selX, i_selY  in  clog2(N_CH) each  channel pair used for intersection and symmetric-difference counts.
REQ-012 i_wr_cfg  in  1  pulse; configuration changed, restart window.
REQ-013 i_flush  in  1  empty FIFO, abort packet, clear overflow.
REQ-014 o_valid / i_ready / o_data[7:0]  out/in/out  byte stream; transfer when o_valid && i_ready.
REQ-015 o_overflow  out  1  sticky; a packet was dropped.
REQ-016 o_winNum  out  8  wrapping window counter.

Function
REQ-017 Sample strobe SHALL assert one cycle in every 2^i_samplePeriodExp cycles; exponent 0 gives a strobe every cycle.
REQ-018 On each strobe: count[c] += i_x[c]; isect += x[selX]&x[selY]; symdiff += x[selX]^x[selY]; each counter TIME_W bits, saturating at all-ones.
REQ-019 Sample index t SHALL increment per strobe; the window ends on the strobe where t == 2^i_windowLengthExp-1, which is included in the counts.
REQ-020 At window end all counts SHALL be snapshotted, counters and t zeroed, and o_winNum incremented (mod 256), regardless of drop.
REQ-021 Reported byte per count = (count << (MAX_WINDOW_LENGTH_EXP - i_windowLengthExp))[TIME_W-1 -: 8], saturated at 8'hFF.
REQ-022 Packet, PKT_LEN = N_CH+3 bytes, in order: winNum (pre-increment value), count[0]..count[N_CH-1], isect, symdiff.
REQ-023 Packetiser FSM states IDLE -> EMIT (one byte pushed per active cycle, PKT_LEN cycles) -> IDLE; first byte pushed the cycle after window end.
REQ-024 Packet SHALL be emitted only if FIFO free entries >= PKT_LEN at window end and FSM is IDLE; otherwise the whole packet is dropped and o_overflow set.
REQ-025 Partial packets SHALL never enter the FIFO.
REQ-026 o_data SHALL remain stable while o_valid && !i_ready; o_valid == !fifo_empty.
REQ-027 Simultaneous push and pop on a full or empty FIFO SHALL both succeed when legal (pop of last entry plus push leaves one entry).
REQ-028 i_wr_cfg SHALL zero counters, t and sample-period counter without emitting a packet or incrementing o_winNum; an EMIT already in progress completes.
REQ-029 i_flush SHALL have priority: FIFO emptied, FSM -> IDLE, o_overflow cleared; a window ending on the same cycle is discarded without setting o_overflow, and o_winNum still increments.
REQ-030 i_selX/i_selY changes take effect on the next strobe; i_selX == i_selY SHALL give isect = count[selX], symdiff = 0.

Reset
REQ-031 Reset SHALL apply when i_rst is high at a rising edge, independent of i_cg.
REQ-032 After reset: o_valid=0, o_overflow=0, o_winNum=0, o_data don't-care, FSM IDLE, all counters, t, and strobe counter 0.
REQ-033 Reset during EMIT SHALL discard the packet and leave the FIFO empty.

Structure
REQ-034 Package correlator_pkg SHALL hold the FSM state enum, the PKT_LEN function of N_CH, and the packet byte-index constants.
REQ-035 The FIFO SHALL be an instance of the existing fifo module (WIDTH 8, DEPTH PKTFIFO_DEPTH); no other sub-module.

Verification (N_CH=4, MAX_WINDOW_LENGTH_EXP=8, PKTFIFO_DEPTH=16, i_ready=1 unless stated)
REQ-036 i_x=4'b0011, sel=(0,1), windowExp=8, periodExp=0 -> bytes 00,FF,FF,00,00,FF,00 (saturation).
REQ-037 windowExp=4, x[0]=x[1] toggling each cycle, x[3:2]=0 -> bytes 00,80,80,00,00,80,00; next header 01.
REQ-038 i_ready=0, windowExp=3: first two packets (14 bytes) accepted, third dropped, o_overflow=1; draining shows headers 00,01 then a header of 03 or later.
REQ-039 i_rst asserted on the 3rd EMIT byte -> o_valid=0 next cycle, o_winNum=0, next packet header 00.
REQ-040 i_flush coincident with window end -> FIFO empty, o_overflow=0, o_winNum incremented, next packet header one greater.
REQ-041 i_wr_cfg mid-window (t=5, windowExp=4) -> no packet; next packet after exactly 16 further strobes.

Source files
------------

// File: rtl/correlator_multi_pkg.sv
// Shared types and packet layout for the multi-channel correlator.
// Packet: header (window number), one byte per channel count, intersection, symmetric difference.
package correlator_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } pkt_state_t;

    localparam int IDX_HDR  = 0;
    localparam int IDX_CNT0 = 1;

    function automatic int pkt_len(input int n_ch);
        return n_ch + 3;
    endfunction

    function automatic int idx_isect(input int n_ch);
        return n_ch + 1;
    endfunction

    function automatic int idx_symdiff(input int n_ch);
        return n_ch + 2;
    endfunction

endpackage

// File: rtl/correlator_multi_if.sv
// Byte stream from the correlator packet FIFO.
// Handshake: a byte moves on a rising edge where valid && ready; while valid && !ready, data holds.
interface correlator_multi_if;

    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/correlator_multi_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees room for a push in the same cycle.
// Flush empties the FIFO and has priority over push and pop.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/correlator_multi.sv
// Windowed coincidence counter over N_CH binary channels; each finished window is
// packetised into bytes and queued in a FIFO, or dropped whole when there is no room.
module correlator_multi
    import correlator_pkg::*;
#(
    parameter int N_CH                  = 4,
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int MAX_SAMPLE_PERIOD_EXP = 15,
    parameter int PKTFIFO_DEPTH         = 64
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_cg,
    input  logic [N_CH-1:0]                          i_x,
    input  logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] i_windowLengthExp,
    input  logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0] i_samplePeriodExp,
    input  logic [$clog2(N_CH)-1:0]                  i_selX,
    input  logic [$clog2(N_CH)-1:0]                  i_selY,
    input  logic                                     i_wr_cfg,
    input  logic                                     i_flush,
    correlator_multi_if.master                       bus,
    output logic                                     o_overflow,
    output logic [7:0]                               o_winNum,
    output pkt_state_t                               o_state
);

    localparam int TIME_W    = MAX_WINDOW_LENGTH_EXP;
    localparam int WEXP_W    = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
    localparam int PEXP_W    = $clog2(MAX_SAMPLE_PERIOD_EXP + 1);
    localparam int PER_W     = (MAX_SAMPLE_PERIOD_EXP < 1) ? 1 : MAX_SAMPLE_PERIOD_EXP;
    localparam int PKT_LEN   = pkt_len(N_CH);
    localparam int IDX_W     = $clog2(PKT_LEN);
    localparam int CNT_W     = $clog2(PKTFIFO_DEPTH + 1);
    localparam int NCNT      = N_CH + 2;
    localparam int IDX_ISECT = idx_isect(N_CH);
    localparam int IDX_SYMD  = idx_symdiff(N_CH);

    pkt_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [WEXP_W-1:0]  wexp;
    logic [PEXP_W-1:0]  pexp;
    logic [PER_W-1:0]   pcnt;
    logic [PER_W-1:0]   last_p;
    logic [TIME_W-1:0]  t;
    logic [TIME_W-1:0]  last_t;
    logic [NCNT-1:0]    smp;
    logic [TIME_W-1:0]  cnt [NCNT];
    logic [TIME_W-1:0]  nxt [NCNT];
    logic [7:0]         pkt [PKT_LEN];
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               strobe, win_end, win_go, room, emit_go, push;

    // Out-of-range exponents are clamped so the window never exceeds the counter width.
    always_comb begin
        wexp = i_windowLengthExp;
        if (i_windowLengthExp > WEXP_W'(MAX_WINDOW_LENGTH_EXP)) wexp = WEXP_W'(MAX_WINDOW_LENGTH_EXP);
        pexp = i_samplePeriodExp;
        if (i_samplePeriodExp > PEXP_W'(MAX_SAMPLE_PERIOD_EXP)) pexp = PEXP_W'(MAX_SAMPLE_PERIOD_EXP);
    end

    assign last_p  = PER_W'((32'd1 << pexp) - 32'd1);
    assign last_t  = TIME_W'((32'd1 << wexp) - 32'd1);
    assign strobe  = (pcnt >= last_p);
    assign win_end = strobe && (t >= last_t);
    assign win_go  = win_end && !i_wr_cfg;
    assign room    = (CNT_W'(PKTFIFO_DEPTH) - fifo_count) >= CNT_W'(PKT_LEN);
    assign emit_go = win_go && (state == ST_IDLE) && room && !i_flush;
    assign push    = i_cg && (state == ST_EMIT);
    assign o_state = state;

    always_comb begin
        smp = {i_x[i_selX] ^ i_x[i_selY], i_x[i_selX] & i_x[i_selY], i_x};
        for (int i = 0; i < NCNT; i++) begin
            nxt[i] = (smp[i] && (cnt[i] != '1)) ? cnt[i] + TIME_W'(1) : cnt[i];
        end
    end

    // Scales a count to full range for the current window, taking the top byte.
    function automatic logic [7:0] to_byte(input logic [TIME_W-1:0] c, input logic [WEXP_W-1:0] we);
        logic [2*TIME_W-1:0] wide;
        wide = {{TIME_W{1'b0}}, c} << (MAX_WINDOW_LENGTH_EXP - int'(we));
        if (|wide[2*TIME_W-1:TIME_W]) return 8'hFF;
        return wide[TIME_W-1 -: 8];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pcnt       <= '0;
            t          <= '0;
            cnt        <= '{default: '0};
            o_winNum   <= '0;
            o_overflow <= 1'b0;
            state      <= ST_IDLE;
            idx        <= '0;
        end else if (i_cg) begin
            if (i_wr_cfg) begin
                pcnt <= '0;
                t    <= '0;
                cnt  <= '{default: '0};
            end else begin
                pcnt <= strobe ? '0 : pcnt + PER_W'(1);
                if (win_end) begin
                    t        <= '0;
                    cnt      <= '{default: '0};
                    o_winNum <= o_winNum + 8'd1;
                end else if (strobe) begin
                    t   <= t + TIME_W'(1);
                    cnt <= nxt;
                end
            end
            if (i_flush) begin
                state      <= ST_IDLE;
                idx        <= '0;
                o_overflow <= 1'b0;
            end else begin
                if (win_go && !emit_go) o_overflow <= 1'b1;
                case (state)
                    ST_IDLE: begin
                        if (emit_go) begin
                            state <= ST_EMIT;
                            idx   <= '0;
                        end
                    end
                    ST_EMIT: begin
                        if (idx == IDX_W'(PKT_LEN - 1)) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // The snapshot includes the sample taken on the window-ending strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_cg && emit_go) begin
            pkt[IDX_HDR] <= o_winNum;
            for (int c = 0; c < N_CH; c++) begin
                pkt[IDX_CNT0 + c] <= to_byte(nxt[c], wexp);
            end
            pkt[IDX_ISECT] <= to_byte(nxt[N_CH], wexp);
            pkt[IDX_SYMD]  <= to_byte(nxt[N_CH + 1], wexp);
        end
    end

    fifo #(
        .WIDTH (8),
        .DEPTH (PKTFIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_cg && i_flush),
        .push      (push),
        .push_data (pkt[idx]),
        .pop       (i_cg && bus.ready),
        .pop_data  (bus.data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.valid = !fifo_empty;

endmodule

// File: tb/tb_correlator_multi.sv
// Directed bench for correlator_multi: table of single-window vectors plus
// hand-timed sequences for overflow, reset, flush, reconfiguration, period and clock gate.
module tb_correlator_multi;
    import correlator_pkg::*;

    typedef struct packed {
        logic [3:0]  xa;
        logic [3:0]  xb;
        logic [1:0]  sx;
        logic [1:0]  sy;
        logic [3:0]  we;
        logic [47:0] exp_b;
    } vec_t;

    localparam int NVEC = 9;

    logic       clk = 1'b0;
    logic       rst, cg, wr_cfg, flush;
    logic [3:0] x, wexp, pexp;
    logic [1:0] sel_x, sel_y;
    logic       overflow;
    logic [7:0] win_num;
    pkt_state_t state;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] exp_win;
    vec_t       vecs [NVEC];

    correlator_multi_if bus ();

    correlator_multi #(
        .N_CH                  (4),
        .MAX_WINDOW_LENGTH_EXP (8),
        .MAX_SAMPLE_PERIOD_EXP (15),
        .PKTFIFO_DEPTH         (16)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_cg              (cg),
        .i_x               (x),
        .i_windowLengthExp (wexp),
        .i_samplePeriodExp (pexp),
        .i_selX            (sel_x),
        .i_selY            (sel_y),
        .i_wr_cfg          (wr_cfg),
        .i_flush           (flush),
        .bus               (bus),
        .o_overflow        (overflow),
        .o_winNum          (win_num),
        .o_state           (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && cg && !flush && bus.valid && bus.ready) rx_q.push_back(bus.data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cg = 1'b1; wr_cfg = 1'b0; flush = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (rx_q.size() < n) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d bytes expected=%0d bytes", name, rx_q.size(), n);
        end
    endtask

    task automatic check_packet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a, e;
            e = (exp_q.size() > 0) ? {8'h00, exp_q.pop_front()} : 16'hBAD0;
            a = (rx_q.size() > 0) ? {8'h00, rx_q.pop_front()} : 16'hDEAD;
            check($sformatf("%s[%0d]", name, i), a, e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        sel_x = v.sx; sel_y = v.sy; wexp = v.we; x = 4'b0;
        wr_cfg = 1'b1;
        tick();
        wr_cfg = 1'b0;
        for (int s = 0; s < (1 << v.we); s++) begin
            x = (s % 2 == 1) ? v.xb : v.xa;
            tick();
        end
        x = 4'b0;
    endtask

    // Runs a fresh single window with x=0011 and expects header 00, count0 byte FF.
    task automatic expect_first_pkt(input string name);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        wait_bytes(name, 7, 60);
        check_packet(name, 2);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{xa: 4'b0011, xb: 4'b0011, sx: 2'd0, sy: 2'd1, we: 4'd8, exp_b: 48'hFF_FF_00_00_FF_00};
        vecs[1] = '{xa: 4'b0011, xb: 4'b0000, sx: 2'd0, sy: 2'd1, we: 4'd4, exp_b: 48'h80_80_00_00_80_00};
        vecs[2] = '{xa: 4'b1111, xb: 4'b0000, sx: 2'd0, sy: 2'd3, we: 4'd4, exp_b: 48'h80_80_80_80_80_00};
        vecs[3] = '{xa: 4'b0101, xb: 4'b1010, sx: 2'd0, sy: 2'd1, we: 4'd4, exp_b: 48'h80_80_80_80_00_FF};
        vecs[4] = '{xa: 4'b1001, xb: 4'b0001, sx: 2'd3, sy: 2'd3, we: 4'd4, exp_b: 48'hFF_00_00_80_80_00};
        vecs[5] = '{xa: 4'b0110, xb: 4'b0010, sx: 2'd1, sy: 2'd2, we: 4'd5, exp_b: 48'h00_FF_80_00_80_80};
        vecs[6] = '{xa: 4'b1000, xb: 4'b1100, sx: 2'd3, sy: 2'd2, we: 4'd6, exp_b: 48'h00_00_80_FF_80_80};
        vecs[7] = '{xa: 4'b0001, xb: 4'b0000, sx: 2'd0, sy: 2'd1, we: 4'd8, exp_b: 48'h80_00_00_00_00_80};
        vecs[8] = '{xa: 4'b0000, xb: 4'b0000, sx: 2'd0, sy: 2'd1, we: 4'd4, exp_b: 48'h00_00_00_00_00_00};

        x = 4'b0; wexp = 4'd8; pexp = 4'd0; sel_x = 2'd0; sel_y = 2'd1; bus.ready = 1'b1;
        do_reset();
        check("rst_valid", 16'(bus.valid), 16'h0);
        check("rst_overflow", 16'(overflow), 16'h0);
        check("rst_winnum", 16'(win_num), 16'h0);
        check("rst_state", 16'(state), 16'(ST_IDLE));

        exp_win = 8'h00;
        for (int i = 0; i < NVEC; i++) begin
            vec_t v;
            v = vecs[i];
            run_vec(v);
            exp_q.push_back(exp_win);
            for (int b = 0; b < 6; b++) exp_q.push_back(v.exp_b[47 - 8*b -: 8]);
            exp_win++;
            wait_bytes($sformatf("vec%0d", i), 7, 40);
            check_packet($sformatf("vec%0d", i), 7);
            check($sformatf("vec%0d_winnum", i), 16'(win_num), 16'(exp_win));
        end

        // Reset must act with the clock gate low.
        cg = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_cg_low_winnum", 16'(win_num), 16'h0);
        check("rst_cg_low_valid", 16'(bus.valid), 16'h0);
        cg = 1'b1;

        // Reset on the third EMIT byte.
        x = 4'b0011; wexp = 4'd4; sel_x = 2'd0; sel_y = 2'd1; bus.ready = 1'b1;
        do_reset();
        repeat (18) tick();
        check("emit_mid_valid", 16'(bus.valid), 16'h1);
        rst = 1'b1;
        tick();
        check("emit_rst_valid", 16'(bus.valid), 16'h0);
        check("emit_rst_winnum", 16'(win_num), 16'h0);
        rst = 1'b0;
        rx_q.delete();
        expect_first_pkt("emit_rst_next");

        // Overflow with the consumer stalled.
        wexp = 4'd3; bus.ready = 1'b0;
        do_reset();
        repeat (40) tick();
        check("ovf_flag", 16'(overflow), 16'h1);
        check("ovf_valid", 16'(bus.valid), 16'h1);
        check("ovf_hold0", 16'(bus.data), 16'h00);
        repeat (3) tick();
        check("ovf_hold1", 16'(bus.data), 16'h00);
        bus.ready = 1'b1;
        wait_bytes("ovf_drain", 21, 120);
        check("ovf_hdr0", 16'((rx_q.size() > 0) ? rx_q[0] : 8'hEE), 16'h00);
        check("ovf_byte1", 16'((rx_q.size() > 1) ? rx_q[1] : 8'hEE), 16'hFF);
        check("ovf_hdr1", 16'((rx_q.size() > 7) ? rx_q[7] : 8'hEE), 16'h01);
        begin
            logic [7:0] h2;
            h2 = (rx_q.size() > 14) ? rx_q[14] : 8'h00;
            checks++;
            if (h2 < 8'h03) begin
                failures++;
                $display("FAIL ovf_hdr2 actual=%0h expected>=03", h2);
            end
        end
        rx_q.delete();

        // Flush on the same edge as a window end.
        wexp = 4'd4; bus.ready = 1'b0;
        do_reset();
        repeat (63) tick();
        check("flush_pre_ovf", 16'(overflow), 16'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 16'(bus.valid), 16'h0);
        check("flush_ovf", 16'(overflow), 16'h0);
        check("flush_winnum", 16'(win_num), 16'h4);
        bus.ready = 1'b1;
        rx_q.delete();
        exp_q.push_back(8'h04);
        wait_bytes("flush_next", 7, 40);
        check_packet("flush_next", 1);
        check("flush_next_ovf", 16'(overflow), 16'h0);
        rx_q.delete();

        // Reconfiguration at t=5 restarts the window.
        do_reset();
        repeat (5) tick();
        wr_cfg = 1'b1;
        tick();
        wr_cfg = 1'b0;
        repeat (15) tick();
        check("cfg_no_early_winnum", 16'(win_num), 16'h0);
        check("cfg_no_early_valid", 16'(bus.valid), 16'h0);
        tick();
        check("cfg_end_winnum", 16'(win_num), 16'h1);
        expect_first_pkt("cfg_pkt");

        // Sample period of 4 cycles stretches a 16-sample window to 64 cycles.
        pexp = 4'd2;
        do_reset();
        repeat (56) tick();
        check("period_early_winnum", 16'(win_num), 16'h0);
        repeat (14) tick();
        check("period_end_winnum", 16'(win_num), 16'h1);
        expect_first_pkt("period_pkt");
        pexp = 4'd0;

        // Ten gated cycles delay the window end by ten cycles.
        do_reset();
        repeat (4) tick();
        cg = 1'b0;
        repeat (10) tick();
        cg = 1'b1;
        repeat (6) tick();
        check("cg_hold_winnum", 16'(win_num), 16'h0);
        repeat (7) tick();
        check("cg_end_winnum", 16'(win_num), 16'h1);
        expect_first_pkt("cg_pkt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
